hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Central stall/flush controller for the five-stage pipeline: the producer of the `stall_load_reg_t` load enables that every pipeline register and the PC consume. It observes the I-cache and D-cache handshakes, the instruction in IF/ID, the instruction in ID/EX, and the branch resolution in EX. From these it decides each cycle which stages advance, which hold and where bubbles are inserted. It sits beside the datapath, with no data of its own on the datapath.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `icache_read` in 1: fetch request active.
- `icache_resp` in 1: fetch data valid this cycle.
- `dcache_read`, `dcache_write` in 1 each: MEM-stage access active.
- `dcache_resp` in 1: MEM access complete this cycle.
- `if_id_opcode` in `rv32i_opcode`: opcode of the instruction in ID.
- `if_id_rs1`, `if_id_rs2` in `rv32i_reg`: source registers of the instruction in ID.
- `id_ex_opcode` in `rv32i_opcode`: opcode of the instruction in EX.
- `id_ex_rd` in `rv32i_reg`: destination register of the instruction in EX.
- `ex_redirect` in 1: EX resolved a taken branch or a jal/jalr; the PC mux already selects the target.
- `load_o` out `stall_load_reg_t`: load enables for pc, if_id, id_ex, ex_mem and mem_wb.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: when the register loads, it loads a NOP bubble instead of its input.

## Operation
- States: RUN, IMISS, DMISS, BR_WAIT. Reset state is RUN. While `rst_n` is low, all loads and flushes are 0.
- Uses of rs1 and rs2:
  - ID uses rs1 unless its opcode is lui, auipc or jal.
  - ID uses rs2 only for op_reg, op_store and op_br.
- `dmiss` = (`dcache_read` | `dcache_write`) & !`dcache_resp`.
- `imiss` = `icache_read` & !`icache_resp`.
- `lu` = (`id_ex_opcode` == op_load) & `id_ex_rd` != 0 & (`id_ex_rd` matches a used rs).
- Priority, evaluated every cycle in any state:
  1. `dmiss`: all loads 0, flushes 0. State is DMISS.
  2. `ex_redirect` & `imiss`:
     - load_pc, load_if_id and load_id_ex are 0.
     - load_ex_mem and load_mem_wb are 1, with `flush_ex_mem` 1 so the held branch is not duplicated.
     - State is BR_WAIT.
  3. `ex_redirect` (no imiss): all loads 1, `flush_if_id` = `flush_id_ex` = 1. State is RUN.
  4. `lu`: load_pc and load_if_id are 0; the others are 1 with `flush_id_ex` = 1. State is RUN.
  5. `imiss`: load_pc = 0; the others are 1 with `flush_if_id` = 1. State is IMISS.
  6. Otherwise: all loads 1, no flush. State is RUN.
- Cycles with no active dcache access cannot stall on the D-cache. `dcache_resp` outside a request is ignored.
- In BR_WAIT the branch stays held in EX until `icache_resp`. On that cycle rule 3 applies, and the wrong-path fetch is discarded by `flush_if_id`.
- The state register exists for observability and the counters. Outputs are a pure function of the inputs, so a response in the same cycle as its request causes no stall.

## Timing
- All outputs are combinational from the inputs; there is zero added latency.
- The state register updates on the rising edge of `clk` and resets asynchronously to RUN.
- A load-use hazard costs exactly 1 bubble cycle.
- A miss stalls for N cycles, where N is the number of cycles with resp low.
- When `rst_n` is asserted mid-miss, outputs go to 0 immediately and the controller resumes in RUN after release.
- A dmiss that coincides with `ex_redirect`: everything freezes, and the redirect is re-evaluated on the release cycle, because EX still holds the branch.

## Configuration
- `HAZ_PERF_CNT_EN` defined: adds output ports `perf_imiss`, `perf_dmiss`, `perf_lu` and `perf_flush`, each 32 bits.
  - Each counts the cycles in which rule 5, 1, 4 or 3 (respectively) fired.
  - Counters wrap modulo 2^32 and reset to 0.
- `HAZ_PERF_CNT_EN` undefined: the counter ports and logic are absent, and the behaviour is otherwise identical.

## Structure
- The state enum `haz_state_e` and the `stall_load_reg_t` type belong in the shared `pipe_types` package.
- The opcode-based "uses rs1/rs2" decode is a natural sub-module, `src_use_decode`. It is also reused by the forwarding unit.

## Test plan
- ID/EX is `lw x5` and ID is `add x6,x5,x1`, no misses → one cycle with load_pc = 0, load_if_id = 0 and `flush_id_ex` = 1; the next cycle all loads are 1.
- Same as above but `id_ex_rd` = x0 → no stall.
- `dcache_read` = 1 with `dcache_resp` low for 4 cycles → all loads 0 for 4 cycles; all loads 1 on the resp cycle; counter `perf_dmiss` = 4.
- `imiss` for 3 cycles → load_pc = 0 and `flush_if_id` = 1 for 3 cycles; normal operation on resp.
- `ex_redirect` during a 2-cycle imiss → BR_WAIT for 2 cycles with `flush_ex_mem` = 1. On the resp cycle all loads are 1 and `flush_if_id` = `flush_id_ex` = 1.
- `rst_n` is dropped mid-DMISS → all outputs 0 asynchronously; after release, state is RUN and all loads are 1.

Source files
------------

// File: rtl/pipe_types.sv
// Shared pipeline types: opcodes, register index, stall/flush controller state and load enables.
package pipe_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stall_load_reg_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IMISS   = 2'd1,
    DMISS   = 2'd2,
    BR_WAIT = 2'd3
  } haz_state_e;

  // Which priority rule decided the current cycle; HAZ_RESET covers rst_n low.
  typedef enum logic [2:0] {
    HAZ_RESET     = 3'd0,
    HAZ_DMISS     = 3'd1,
    HAZ_BR_IMISS  = 3'd2,
    HAZ_REDIRECT  = 3'd3,
    HAZ_LOAD_USE  = 3'd4,
    HAZ_IMISS     = 3'd5,
    HAZ_RUN       = 3'd6
  } haz_rule_e;

  localparam stall_load_reg_t LOAD_NONE = 5'b00000;
  localparam stall_load_reg_t LOAD_ALL  = 5'b11111;

  function automatic logic src_hit(input rv32i_reg rd, input rv32i_reg rs, input logic used);
    return used && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic haz_state_e rule_state(input haz_rule_e rule);
    case (rule)
      HAZ_DMISS:    return DMISS;
      HAZ_BR_IMISS: return BR_WAIT;
      HAZ_IMISS:    return IMISS;
      default:      return RUN;
    endcase
  endfunction

endpackage

// File: rtl/src_use_decode.sv
// Opcode decode of whether an instruction reads rs1 and/or rs2; shared with the forwarding unit.
module src_use_decode
  import pipe_types::*;
(
  input  rv32i_opcode opcode,
  output logic        use_rs1,
  output logic        use_rs2
);

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      op_lui, op_auipc, op_jal: use_rs1 = 1'b0;
      default: ;
    endcase
    case (opcode)
      op_reg, op_store, op_br: use_rs2 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller; optional cycle counters under HAZ_PERF_CNT_EN.
//   state   | meaning
//   RUN     | pipeline advancing (incl. single load-use bubble or redirect)
//   IMISS   | fetch miss, PC held, bubbles into IF/ID
//   DMISS   | data miss, whole pipeline frozen
//   BR_WAIT | redirect waiting on fetch of the target, branch held in EX
module hazard_stall_ctrl
  import pipe_types::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            icache_read,
  input  logic            icache_resp,
  input  logic            dcache_read,
  input  logic            dcache_write,
  input  logic            dcache_resp,
  input  rv32i_opcode     if_id_opcode,
  input  rv32i_reg        if_id_rs1,
  input  rv32i_reg        if_id_rs2,
  input  rv32i_opcode     id_ex_opcode,
  input  rv32i_reg        id_ex_rd,
  input  logic            ex_redirect,
  output stall_load_reg_t load_o,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_imiss,
  output logic [31:0]     perf_dmiss,
  output logic [31:0]     perf_lu,
  output logic [31:0]     perf_flush
`endif
);

  logic       use_rs1;
  logic       use_rs2;
  logic       dmiss;
  logic       imiss;
  logic       lu;
  haz_rule_e  rule;
  haz_state_e state_q;
  haz_state_e state_d;

  src_use_decode u_src_use (
    .opcode  (if_id_opcode),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign dmiss = (dcache_read | dcache_write) & ~dcache_resp;
  assign imiss = icache_read & ~icache_resp;
  assign lu    = (id_ex_opcode == op_load) &
                 (src_hit(id_ex_rd, if_id_rs1, use_rs1) | src_hit(id_ex_rd, if_id_rs2, use_rs2));

  // Outputs depend only on inputs so a same-cycle response never stalls.
  always_comb begin
    load_o       = LOAD_NONE;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    rule         = HAZ_RESET;
    if (rst_n) begin
      if (dmiss) begin
        rule = HAZ_DMISS;
      end else if (ex_redirect && imiss) begin
        // Let the branch drain into MEM once but as a bubble; EX keeps the original.
        load_o.ex_mem = 1'b1;
        load_o.mem_wb = 1'b1;
        flush_ex_mem  = 1'b1;
        rule          = HAZ_BR_IMISS;
      end else if (ex_redirect) begin
        load_o      = LOAD_ALL;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        rule        = HAZ_REDIRECT;
      end else if (lu) begin
        load_o.id_ex  = 1'b1;
        load_o.ex_mem = 1'b1;
        load_o.mem_wb = 1'b1;
        flush_id_ex   = 1'b1;
        rule          = HAZ_LOAD_USE;
      end else if (imiss) begin
        load_o      = LOAD_ALL;
        load_o.pc   = 1'b0;
        flush_if_id = 1'b1;
        rule        = HAZ_IMISS;
      end else begin
        load_o = LOAD_ALL;
        rule   = HAZ_RUN;
      end
    end
  end

  always_comb begin
    state_d = rule_state(rule);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {RUN, IMISS, DMISS, BR_WAIT});

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_imiss <= '0;
      perf_dmiss <= '0;
      perf_lu    <= '0;
      perf_flush <= '0;
    end else begin
      if (rule == HAZ_IMISS)    perf_imiss <= perf_imiss + 32'd1;
      if (rule == HAZ_DMISS)    perf_dmiss <= perf_dmiss + 32'd1;
      if (rule == HAZ_LOAD_USE) perf_lu    <= perf_lu + 32'd1;
      if (rule == HAZ_REDIRECT) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_stall_ctrl;
  import pipe_types::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            icache_read = 1'b1;
  logic            icache_resp = 1'b1;
  logic            dcache_read = 1'b0;
  logic            dcache_write = 1'b0;
  logic            dcache_resp = 1'b0;
  rv32i_opcode     if_id_opcode = op_imm;
  rv32i_reg        if_id_rs1 = '0;
  rv32i_reg        if_id_rs2 = '0;
  rv32i_opcode     id_ex_opcode = op_imm;
  rv32i_reg        id_ex_rd = '0;
  logic            ex_redirect = 1'b0;
  stall_load_reg_t load_o;
  logic            flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]     perf_imiss, perf_dmiss, perf_lu, perf_flush;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_read  (icache_read),
    .icache_resp  (icache_resp),
    .dcache_read  (dcache_read),
    .dcache_write (dcache_write),
    .dcache_resp  (dcache_resp),
    .if_id_opcode (if_id_opcode),
    .if_id_rs1    (if_id_rs1),
    .if_id_rs2    (if_id_rs2),
    .id_ex_opcode (id_ex_opcode),
    .id_ex_rd     (id_ex_rd),
    .ex_redirect  (ex_redirect),
    .load_o       (load_o),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_imiss   (perf_imiss),
    .perf_dmiss   (perf_dmiss),
    .perf_lu      (perf_lu),
    .perf_flush   (perf_flush)
`endif
  );

  typedef struct {
    logic [4:0]  load;
    logic [2:0]  fl;
    logic [31:0] pi, pd, pl, pf;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pi = 0, m_pd = 0, m_pl = 0, m_pf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, one expectation per cycle.
  exp_t        e;
  logic [4:0]  la;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      la = load_o;
      chk({e.nm, ".load"}, {27'd0, la}, {27'd0, e.load});
      chk({e.nm, ".flush"}, {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {29'd0, e.fl});
`ifdef HAZ_PERF_CNT_EN
      chk({e.nm, ".perf_imiss"}, perf_imiss, e.pi);
      chk({e.nm, ".perf_dmiss"}, perf_dmiss, e.pd);
      chk({e.nm, ".perf_lu"}, perf_lu, e.pl);
      chk({e.nm, ".perf_flush"}, perf_flush, e.pf);
`endif
    end
  end

  // One pipeline cycle: drive inputs, push hand-computed loads/flushes; rule drives the counter model.
  task automatic cyc(input logic rst, input logic ir, input logic irsp, input logic [1:0] dacc,
                     input logic drsp, input rv32i_opcode ido, input rv32i_reg rs1, input rv32i_reg rs2,
                     input rv32i_opcode exo, input rv32i_reg rd, input logic redir,
                     input logic [4:0] el, input logic [2:0] ef, input int rule, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n        = rst;
    icache_read  = ir;
    icache_resp  = irsp;
    dcache_read  = dacc[1];
    dcache_write = dacc[0];
    dcache_resp  = drsp;
    if_id_opcode = ido;
    if_id_rs1    = rs1;
    if_id_rs2    = rs2;
    id_ex_opcode = exo;
    id_ex_rd     = rd;
    ex_redirect  = redir;
    if (!rst) begin
      m_pi = 0; m_pd = 0; m_pl = 0; m_pf = 0;
    end
    x.load = el; x.fl = ef; x.nm = nm;
    x.pi = m_pi; x.pd = m_pd; x.pl = m_pl; x.pf = m_pf;
    sb.push_back(x);
    case (rule)
      1: m_pd++;
      3: m_pf++;
      4: m_pl++;
      5: m_pi++;
      default: ;
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(0,1,1,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,0,"reset");
    cyc(1,1,1,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"idle");
    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    cyc(1,1,1,2'b00,0, op_reg,5,1, op_load,5, 0, 5'b00111,3'b010,4,"lu_rs1");
    cyc(1,1,1,2'b00,0, op_reg,5,1, op_imm,0,  0, 5'b11111,3'b000,6,"lu_after");
    cyc(1,1,1,2'b00,0, op_reg,0,1, op_load,0, 0, 5'b11111,3'b000,6,"lu_x0");
    cyc(1,1,1,2'b00,0, op_store,2,7, op_load,7, 0, 5'b00111,3'b010,4,"lu_store_rs2");
    cyc(1,1,1,2'b00,0, op_imm,2,7,   op_load,7, 0, 5'b11111,3'b000,6,"imm_no_rs2");
    cyc(1,1,1,2'b00,0, op_lui,7,7,   op_load,7, 0, 5'b11111,3'b000,6,"lui_no_rs1");
    cyc(1,1,1,2'b00,0, op_jalr,7,0,  op_load,7, 0, 5'b00111,3'b010,4,"lu_jalr_rs1");
    cyc(1,1,1,2'b00,0, op_br,1,9,    op_load,9, 0, 5'b00111,3'b010,4,"lu_br_rs2");
    cyc(1,1,1,2'b00,0, op_reg,9,9,   op_store,9,0, 5'b11111,3'b000,6,"store_in_ex");
    // 4-cycle dcache read miss
    for (int i = 0; i < 4; i++)
      cyc(1,1,1,2'b10,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,1,"dmiss");
    cyc(1,1,1,2'b10,1, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"dmiss_resp");
    cyc(1,1,1,2'b01,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,1,"dwrite_miss");
    cyc(1,1,1,2'b01,1, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"dwrite_resp");
    cyc(1,1,1,2'b00,1, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"stray_dresp");
    // 3-cycle fetch miss
    for (int i = 0; i < 3; i++)
      cyc(1,1,0,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b01111,3'b100,5,"imiss");
    cyc(1,1,1,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"imiss_resp");
    cyc(1,0,0,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"no_fetch");
    // redirect during a 2-cycle fetch miss
    for (int i = 0; i < 2; i++)
      cyc(1,1,0,2'b00,0, op_imm,0,0, op_br,0, 1, 5'b00011,3'b001,2,"br_wait");
    cyc(1,1,1,2'b00,0, op_imm,0,0, op_br,0, 1, 5'b11111,3'b110,3,"br_wait_resp");
    // dmiss freezes a redirect, redirect taken on release
    cyc(1,1,0,2'b10,0, op_imm,0,0, op_br,0, 1, 5'b00000,3'b000,1,"dmiss_redir");
    cyc(1,1,1,2'b10,1, op_imm,0,0, op_br,0, 1, 5'b11111,3'b110,3,"redir_release");
    // priority corners
    cyc(1,1,0,2'b00,0, op_reg,5,1, op_load,5, 0, 5'b00111,3'b010,4,"lu_over_imiss");
    cyc(1,1,1,2'b00,0, op_reg,5,1, op_load,5, 1, 5'b11111,3'b110,3,"redir_over_lu");
    cyc(1,1,1,2'b10,0, op_reg,5,1, op_load,5, 0, 5'b00000,3'b000,1,"dmiss_over_lu");
    // reset asserted mid-DMISS
    cyc(1,1,1,2'b10,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,1,"dmiss_pre_rst");
    cyc(0,1,1,2'b10,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,0,"rst_mid_dmiss");
    cyc(0,1,1,2'b10,0, op_imm,0,0, op_imm,0, 0, 5'b00000,3'b000,0,"rst_hold");
    cyc(1,1,1,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"after_rst");
    cyc(1,1,0,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b01111,3'b100,5,"imiss_after_rst");
    cyc(1,1,1,2'b00,0, op_imm,0,0, op_imm,0, 0, 5'b11111,3'b000,6,"final");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
